// File: rtl/cc_pkg.sv
//------------------------------------------------------------------------------
// Module  : cc_pkg
// Brief   : Condition-code types, reset value and bus classification helper.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cc_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } cc_t;

  localparam cc_t CC_RESET = 3'b010;

  // Widest bus the classifier accepts; callers sign-extend narrower buses.
  localparam int CC_MAX_W = 64;

  function automatic cc_t cc_classify(input logic signed [CC_MAX_W-1:0] data);
    cc_t r;
    r = '0;
    if (data[CC_MAX_W-1]) begin
      r.n = 1'b1;
    end else if (data == '0) begin
      r.z = 1'b1;
    end else begin
      r.p = 1'b1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cc_branch_unit_if.sv
//------------------------------------------------------------------------------
// Module  : cc_branch_unit_if
// Brief   : Control/bus bundle between datapath, control FSM and branch unit.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cc_branch_unit_if #(
  parameter int WIDTH = 16
);
  logic             LD_CC;
  logic [WIDTH-1:0] bus_data;
  logic             LD_BEN;
  logic [2:0]       ir_nzp;
  logic             cc_push;
  logic             cc_pop;
  logic             err_clr;
  logic [2:0]       nzp;
  logic             BEN;
  logic             stack_full;
  logic             stack_empty;
  logic             stack_err;

  modport master (
    output LD_CC, bus_data, LD_BEN, ir_nzp, cc_push, cc_pop, err_clr,
    input  nzp, BEN, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  LD_CC, bus_data, LD_BEN, ir_nzp, cc_push, cc_pop, err_clr,
    output nzp, BEN, stack_full, stack_empty, stack_err
  );
endinterface

`default_nettype wire

// File: rtl/cc_stack.sv
//------------------------------------------------------------------------------
// Module  : cc_stack
// Brief   : LIFO of saved condition codes with full/empty and error strobes.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cc_stack
  import cc_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  wire  Clk,
  input  wire  Reset,
  input  wire  push,
  input  wire  pop,
  input  cc_t  din,
  output cc_t  dout,
  output logic full,
  output logic empty,
  output logic err_ovf,
  output logic err_unf
);

  localparam int PW = $clog2(STACK_DEPTH + 1);
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PW-1:0] depth_q, depth_d;
  cc_t           mem_q [STACK_DEPTH];
  logic          push_ok, pop_ok;
  logic [AW-1:0] wr_idx, top_idx;

  assign full    = (depth_q == PW'(STACK_DEPTH));
  assign empty   = (depth_q == '0);
  // Simultaneous push and pop is a conflict: neither side acts.
  assign push_ok = push & ~pop & ~full;
  assign pop_ok  = pop & ~push & ~empty;
  assign err_ovf = push & ~pop & full;
  assign err_unf = pop & ~push & empty;

  assign wr_idx  = AW'(depth_q);
  assign top_idx = AW'(depth_q - PW'(1));
  assign dout    = empty ? CC_RESET : mem_q[top_idx];

  always_comb begin
    depth_d = depth_q;
    if (push_ok) begin
      depth_d = depth_q + PW'(1);
    end else if (pop_ok) begin
      depth_d = depth_q - PW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push_ok) begin
      mem_q[wr_idx] <= din;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cc_branch_unit.sv
//------------------------------------------------------------------------------
// Module  : cc_branch_unit
// Brief   : NZP condition codes, registered BEN and saved-CC stack.
//           Define CC_FWD_EN to evaluate BEN against a same-cycle CC load.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cc_branch_unit
  import cc_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4
) (
  input wire              Clk,
  input wire              Reset,
  cc_branch_unit_if.slave bus
);

  cc_t  nzp_q, nzp_d;
  logic ben_q, ben_d;
  logic err_q, err_d;
  cc_t  cc_new, ben_src, stk_dout;
  logic stk_full, stk_empty, err_ovf, err_unf, conflict, pop_ok;

  assign cc_new = cc_classify(CC_MAX_W'($signed(bus.bus_data)));

  cc_stack #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .Clk    (Clk),
    .Reset  (Reset),
    .push   (bus.cc_push),
    .pop    (bus.cc_pop),
    .din    (nzp_q),
    .dout   (stk_dout),
    .full   (stk_full),
    .empty  (stk_empty),
    .err_ovf(err_ovf),
    .err_unf(err_unf)
  );

  assign conflict = bus.cc_push & bus.cc_pop;
  assign pop_ok   = bus.cc_pop & ~bus.cc_push & ~stk_empty;

`ifdef CC_FWD_EN
  assign ben_src = bus.LD_CC ? cc_new : nzp_q;
`else
  assign ben_src = nzp_q;
`endif

  always_comb begin
    nzp_d = nzp_q;
    if (bus.LD_CC) begin
      nzp_d = cc_new;
    end else if (pop_ok) begin
      nzp_d = stk_dout;
    end

    ben_d = ben_q;
    if (bus.LD_BEN) begin
      ben_d = |(bus.ir_nzp & ben_src);
    end

    // A new error outranks a coincident clear.
    err_d = err_q;
    if (err_ovf | err_unf | conflict) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      nzp_q <= CC_RESET;
      ben_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      nzp_q <= nzp_d;
      ben_q <= ben_d;
      err_q <= err_d;
    end
  end

  assign bus.nzp         = nzp_q;
  assign bus.BEN         = ben_q;
  assign bus.stack_full  = stk_full;
  assign bus.stack_empty = stk_empty;
  assign bus.stack_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cc_branch_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_cc_branch_unit
// Brief   : Directed scoreboard bench for cc_branch_unit (honours CC_FWD_EN).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cc_branch_unit;

  localparam int WIDTH       = 16;
  localparam int STACK_DEPTH = 4;

  typedef struct packed {
    logic [2:0] nzp;
    logic       ben;
    logic       full;
    logic       empty;
    logic       err;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  exp_t       sb_q[$];
  logic [2:0] m_stack[$];
  logic [2:0] m_nzp;
  logic       m_ben;
  logic       m_err;

  cc_branch_unit_if #(.WIDTH(WIDTH)) bus ();

  cc_branch_unit #(
    .WIDTH      (WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] classify(input logic [WIDTH-1:0] d);
    if ($signed(d) < 0) return 3'b100;
    if (d == '0) return 3'b010;
    return 3'b001;
  endfunction

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".nzp"},   bus.nzp,                3'b010);
    check({tag, ".ben"},   {2'b00, bus.BEN},        3'b000);
    check({tag, ".full"},  {2'b00, bus.stack_full}, 3'b000);
    check({tag, ".empty"}, {2'b00, bus.stack_empty},3'b001);
    check({tag, ".err"},   {2'b00, bus.stack_err},  3'b000);
  endtask

  task automatic model_reset();
    m_nzp = 3'b010;
    m_ben = 1'b0;
    m_err = 1'b0;
    m_stack.delete();
    sb_q.delete();
  endtask

  // Drive one cycle of stimulus, queue the model's prediction, clock, compare.
  task automatic step(input string tag, input logic ld_cc, input logic [WIDTH-1:0] data,
                      input logic ld_ben, input logic [2:0] irn,
                      input logic push, input logic pop, input logic clr);
    logic [2:0] cc_new, src, old;
    logic       was_full, was_empty, e_new;
    exp_t       e;
    bus.LD_CC    = ld_cc;
    bus.bus_data = data;
    bus.LD_BEN   = ld_ben;
    bus.ir_nzp   = irn;
    bus.cc_push  = push;
    bus.cc_pop   = pop;
    bus.err_clr  = clr;

    cc_new    = classify(data);
    old       = m_nzp;
    was_full  = (m_stack.size() == STACK_DEPTH);
    was_empty = (m_stack.size() == 0);
`ifdef CC_FWD_EN
    src = ld_cc ? cc_new : old;
`else
    src = old;
`endif
    if (ld_ben) m_ben = |(irn & src);
    e_new = (push & pop) | (push & !pop & was_full) | (pop & !push & was_empty);
    if (push && !pop && !was_full) m_stack.push_back(old);
    if (pop && !push && !was_empty) m_nzp = m_stack.pop_back();
    if (ld_cc) m_nzp = cc_new;
    if (e_new) m_err = 1'b1;
    else if (clr) m_err = 1'b0;

    e.nzp   = m_nzp;
    e.ben   = m_ben;
    e.full  = (m_stack.size() == STACK_DEPTH);
    e.empty = (m_stack.size() == 0);
    e.err   = m_err;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".nzp"},   bus.nzp,                 e.nzp);
    check({tag, ".ben"},   {2'b00, bus.BEN},         {2'b00, e.ben});
    check({tag, ".full"},  {2'b00, bus.stack_full},  {2'b00, e.full});
    check({tag, ".empty"}, {2'b00, bus.stack_empty}, {2'b00, e.empty});
    check({tag, ".err"},   {2'b00, bus.stack_err},   {2'b00, e.err});

    bus.LD_CC   = 1'b0;
    bus.LD_BEN  = 1'b0;
    bus.cc_push = 1'b0;
    bus.cc_pop  = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    bus.LD_CC = 1'b0; bus.bus_data = '0; bus.LD_BEN = 1'b0; bus.ir_nzp = 3'b000;
    bus.cc_push = 1'b0; bus.cc_pop = 1'b0; bus.err_clr = 1'b0;
    model_reset();

    #1 rst = 1'b1;
    #1 check_reset_outputs("por");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Classification and BEN
    step("ld_n",     1, 16'h8000, 0, 3'b000, 0, 0, 0);
    step("ben_n",    0, 16'h0000, 1, 3'b100, 0, 0, 0);
    step("ben_zp",   0, 16'h0000, 1, 3'b011, 0, 0, 0);
    step("ld_z",     1, 16'h0000, 0, 3'b111, 0, 0, 0);
    step("ld_p",     1, 16'h7FFF, 0, 3'b111, 0, 0, 0);
    step("ld_m1",    1, 16'hFFFF, 0, 3'b111, 0, 0, 0);
    step("ben_nzp",  0, 16'h0000, 1, 3'b111, 0, 0, 0);
    step("ben_zero", 0, 16'h0000, 1, 3'b000, 0, 0, 0);

    // Save N, P, Z then restore in reverse order
    step("cc_n",  1, 16'h8001, 0, 3'b000, 0, 0, 0);
    step("push1", 0, 16'h0000, 0, 3'b000, 1, 0, 0);
    step("cc_p",  1, 16'h0001, 0, 3'b000, 0, 0, 0);
    step("push2", 0, 16'h0000, 0, 3'b000, 1, 0, 0);
    step("cc_z",  1, 16'h0000, 0, 3'b000, 0, 0, 0);
    step("push3", 0, 16'h0000, 0, 3'b000, 1, 0, 0);
    step("cc_p2", 1, 16'h1234, 0, 3'b000, 0, 0, 0);
    step("pop1",  0, 16'h0000, 0, 3'b000, 0, 1, 0);
    step("pop2",  0, 16'h0000, 0, 3'b000, 0, 1, 0);
    step("pop3",  0, 16'h0000, 0, 3'b000, 0, 1, 0);

    // Overflow, clear, drain, underflow
    for (int i = 0; i < 5; i++) begin
      step("ovf_ld", 1, (i[0] ? 16'h0042 : 16'hC000), 0, 3'b000, 0, 0, 0);
      step("ovf_push", 0, 16'h0000, 0, 3'b000, 1, 0, 0);
    end
    step("clr",      0, 16'h0000, 0, 3'b000, 0, 0, 1);
    step("clr_set",  0, 16'h0000, 0, 3'b000, 1, 0, 1);
    step("clr2",     0, 16'h0000, 0, 3'b000, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step("drain", 0, 16'h0000, 0, 3'b000, 0, 1, 0);
    end
    step("unf",      0, 16'h0000, 0, 3'b000, 0, 1, 0);
    step("unf_ld",   1, 16'h0000, 0, 3'b000, 0, 1, 1);
    step("clr3",     0, 16'h0000, 0, 3'b000, 0, 0, 1);

    // Same-cycle LD_CC and LD_BEN
    step("fwd_pre",  1, 16'h8000, 0, 3'b000, 0, 0, 0);
    step("fwd",      1, 16'h0005, 1, 3'b001, 0, 0, 0);

    // Conflicts and CC load coinciding with stack traffic
    step("conflict", 0, 16'h0000, 0, 3'b000, 1, 1, 0);
    step("clr4",     0, 16'h0000, 0, 3'b000, 0, 0, 1);
    step("ld_push",  1, 16'hF000, 0, 3'b000, 1, 0, 0);
    step("ld_pop",   1, 16'h0000, 0, 3'b000, 0, 1, 0);
    step("ld_push2", 1, 16'h0003, 0, 3'b000, 1, 0, 0);
    step("ld_push3", 1, 16'h8000, 0, 3'b000, 1, 0, 0);

    // Asynchronous reset mid-cycle while a push is in flight at depth 2
    bus.cc_push = 1'b1;
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    #1 rst = 1'b0;
    bus.cc_push = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_reset_outputs("post_rst");
    step("rst_ld",   1, 16'h8000, 0, 3'b000, 0, 0, 0);
    step("rst_push", 0, 16'h0000, 0, 3'b000, 1, 0, 0);
    step("rst_ld2",  1, 16'h0000, 0, 3'b000, 0, 0, 0);
    step("rst_pop",  0, 16'h0000, 0, 3'b000, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
